// File: rtl/max_capture_pkg.sv
// Shared types and helpers for the max-number finder capture stage.
package max_capture_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // All-ones preset for a register of the given width (width up to 64).
  function automatic logic [63:0] all_ones(input int unsigned width);
    if (width >= 64) begin
      all_ones = '1;
    end else begin
      all_ones = (64'd1 << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Combinational strict greater-than, signed or unsigned by parameter.
module max_cmp #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b_c
);

  always_comb begin
    if (SIGNED) begin
      a_gt_b_c = $signed(a) > $signed(b);
    end else begin
      a_gt_b_c = a > b;
    end
  end

endmodule

// File: rtl/max_capture_reg.sv
// Running-maximum capture register over a framed sample stream, with
// winning-sample index, frame-done pulse and sticky index overflow.
module max_capture_reg
  import max_capture_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      IDX_W     = 4,
  parameter bit               SIGNED    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESETZ,
  input  logic             CLRZ,
  input  logic             SETZ,
  input  logic [WIDTH-1:0] D,
  input  logic             DVALID,
  input  logic             DLAST,
  output logic [WIDTH-1:0] Q,
  output logic [IDX_W-1:0] QIDX,
  output logic             QVALID,
  output logic             DONE,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] PRESET  = WIDTH'(all_ones(WIDTH));
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             qvalid_q, qvalid_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             d_gt_q;

  max_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a        (D),
    .b        (q_q),
    .a_gt_b_c (d_gt_q)
  );

  // Next-state: clear beats preset beats sample processing.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    qvalid_d = qvalid_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    if (!CLRZ) begin
      state_d  = ST_IDLE;
      q_d      = RESET_VAL;
      idx_d    = '0;
      cnt_d    = '0;
      qvalid_d = 1'b0;
      ovf_d    = 1'b0;
    end else if (!SETZ) begin
      q_d = PRESET;
    end else if (DVALID) begin
      if (state_q == ST_RUN) begin
        // Strict compare so ties keep the earliest index.
        if (d_gt_q) begin
          q_d   = D;
          idx_d = cnt_q;
        end
        if (cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end else begin
        q_d      = D;
        idx_d    = '0;
        cnt_d    = IDX_W'(1);
        qvalid_d = 1'b0;
        ovf_d    = 1'b0;
        state_d  = ST_RUN;
      end
      if (DLAST) begin
        state_d  = ST_HOLD;
        qvalid_d = 1'b1;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETZ) begin
    if (!RESETZ) begin
      state_q  <= ST_IDLE;
      q_q      <= RESET_VAL;
      idx_q    <= '0;
      cnt_q    <= '0;
      qvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      qvalid_q <= qvalid_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Q      = q_q;
  assign QIDX   = idx_q;
  assign QVALID = qvalid_q;
  assign DONE   = done_q;
  assign OVF    = ovf_q;

endmodule
